// File: rtl/acc_drain_packer_if.sv
// Output word stream of acc_drain_packer toward the DMA/BRAM writer.
// Handshake: a word transfers on a rising edge where out_valid && out_ready; once out_valid rises, it and out_data/out_last hold until that transfer.
interface acc_drain_packer_if #(
  parameter int OUT_WIDTH = 64
);
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/acc_drain_packer.sv
// Drains accumulator rows one at a time and packs valid columns into OUT_WIDTH-bit stream words.
// Optional feature macro ACC_DRAIN_RELU_EN: clamp negative captured lanes to zero before packing.
module acc_drain_packer #(
  parameter int DEPTH      = 8,
  parameter int ARRAY_M    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(DEPTH):0]        num_rows,
  input  logic [$clog2(ARRAY_M):0]      num_cols,
  input  logic [ARRAY_M*DATA_WIDTH-1:0] acc_in,
  output logic                          drain,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    state_dbg,
  acc_drain_packer_if.master            out_if
);
  localparam int LANES = OUT_WIDTH / DATA_WIDTH;
  localparam int RW    = $clog2(DEPTH) + 1;
  localparam int CW    = $clog2(ARRAY_M) + 1;
  localparam int MAXW  = (ARRAY_M + LANES - 1) / LANES;
  localparam int WW    = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                        state, state_nxt;
  logic [RW-1:0]                 rows_q, row_q, rows_cl;
  logic [CW-1:0]                 cols_q, cols_cl;
  logic [WW-1:0]                 word_q, last_word;
  logic [CW:0]                   words_sum;
  logic [ARRAY_M*DATA_WIDTH-1:0] row_buf, row_cap;
  logic                          accept, word_end, row_end;
  int                            col;

  assign state_dbg = state;
  assign rows_cl   = (num_rows > RW'(DEPTH))   ? RW'(DEPTH)   : num_rows;
  assign cols_cl   = (num_cols > CW'(ARRAY_M)) ? CW'(ARRAY_M) : num_cols;
  // Words per row is ceil(cols/LANES); only meaningful once a non-empty tile is latched.
  assign words_sum = {1'b0, cols_q} + (CW+1)'(LANES - 1);
  assign last_word = WW'(words_sum / (CW+1)'(LANES)) - WW'(1);
  assign word_end  = (word_q == last_word);
  assign row_end   = (row_q == rows_q - RW'(1));
  assign accept    = (state == S_SEND) && out_if.out_ready;

  always_comb begin
    row_cap = acc_in;
`ifdef ACC_DRAIN_RELU_EN
    for (int c = 0; c < ARRAY_M; c++) begin
      if (acc_in[c*DATA_WIDTH + DATA_WIDTH - 1]) row_cap[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (rows_cl == '0 || cols_cl == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SEND;
      S_SEND:    if (accept && word_end) state_nxt = row_end ? S_DONE : S_ISSUE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Tile geometry is frozen at start; a row is buffered only after its previous one fully left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      word_q  <= '0;
      row_buf <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rows_q <= rows_cl;
          cols_q <= cols_cl;
          row_q  <= '0;
        end
        S_CAPTURE: begin
          row_buf <= row_cap;
          word_q  <= '0;
        end
        S_SEND: if (accept) begin
          if (word_end) begin
            word_q <= '0;
            if (!row_end) row_q <= row_q + RW'(1);
          end else begin
            word_q <= word_q + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    drain            = (state == S_ISSUE);
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
    out_if.out_valid = (state == S_SEND);
    out_if.out_last  = (state == S_SEND) && word_end && row_end;
    out_if.out_data  = '0;
    col              = 0;
    if (state == S_SEND) begin
      for (int l = 0; l < LANES; l++) begin
        col = int'(word_q) * LANES + l;
        if (col < int'(cols_q) && col < ARRAY_M)
          out_if.out_data[l*DATA_WIDTH +: DATA_WIDTH] = row_buf[col*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_acc_drain_packer.sv
// Directed bench for acc_drain_packer: accumulator model, expected-word queue, immediate-assert checks.
module tb_acc_drain_packer;
  localparam int DW = 32;
  localparam int M  = 8;
  localparam int OW = 64;
`ifdef ACC_DRAIN_RELU_EN
  localparam logic [DW-1:0] NEG_OUT = 32'd0;
`else
  localparam logic [DW-1:0] NEG_OUT = 32'hFFFF_FFF6;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    num_rows = '0;
  logic [3:0]    num_cols = '0;
  logic [M*DW-1:0] acc_in;
  logic          drain, busy, done;
  logic [2:0]    state_dbg;

  acc_drain_packer_if #(.OUT_WIDTH(OW)) oif();

  acc_drain_packer #(.DEPTH(8), .ARRAY_M(M), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .acc_in(acc_in), .drain(drain), .busy(busy), .done(done), .state_dbg(state_dbg),
    .out_if(oif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  int drain_cnt = 0;
  int row_base = 0;
  int acc_mode = 0;
  int n_drain, done_cyc, last_cyc, busy_cyc, n_last, stall_bad, drain_in_send;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic logic [DW-1:0] acc_val(input int r, input int c);
    if (acc_mode == 1 && c == 0) return 32'hFFFF_FFF6;
    if (acc_mode == 1 && c == 1) return 32'd7;
    return DW'(r * 16 + c);
  endfunction

  // Accumulator: the row requested by drain appears on acc_in the following cycle.
  always @(posedge clk) begin : acc_model
    logic [M*DW-1:0] nxt;
    if (drain) begin
      for (int c = 0; c < M; c++) nxt[c*DW +: DW] = acc_val(drain_cnt - row_base, c);
      acc_in    <= nxt;
      drain_cnt <= drain_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int rows, input int cols);
    int rc, cc, w;
    logic [DW-1:0] v;
    logic [OW-1:0] word;
    exp_q.delete();
    rc = (rows > 8) ? 8 : rows;
    cc = (cols > 8) ? 8 : cols;
    w  = (cc + 1) / 2;
    for (int r = 0; r < rc; r++) begin
      for (int wi = 0; wi < w; wi++) begin
        word = '0;
        for (int l = 0; l < 2; l++) begin
          if (wi * 2 + l < cc) begin
            v = acc_val(r, wi * 2 + l);
`ifdef ACC_DRAIN_RELU_EN
            if (v[DW-1]) v = '0;
`endif
            word[l*DW +: DW] = v;
          end
        end
        exp_q.push_back(word);
      end
    end
  endtask

  // Starts a tile from a negedge and runs cycle by cycle until done (or abort_words accepted).
  task automatic run_tile(input int rows, input int cols, input int mode, input int restart_cyc,
                          input int abort_words);
    logic [OW:0]   held;
    logic          held_v;
    logic [OW-1:0] e;
    bit            fin;
    build_exp(rows, cols);
    got_q.delete();
    n_drain = 0; done_cyc = -1; last_cyc = -1; busy_cyc = 0; n_last = 0;
    stall_bad = 0; drain_in_send = 0; held_v = 1'b0; held = '0; fin = 1'b0;
    row_base = drain_cnt;
    num_rows = 4'(rows);
    num_cols = 4'(cols);
    start = 1'b1;
    oif.out_ready = 1'b0;
    @(negedge clk);
    num_rows = 4'd1;
    num_cols = 4'd1;
    for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
      start = (cyc == restart_cyc);
      oif.out_ready = (mode == 0) ? 1'b1 : pat[(cyc - 1) % 4];
      #1;
      if (busy) busy_cyc++;
      if (drain) n_drain++;
      if (drain && oif.out_valid) drain_in_send++;
      if (held_v && (!oif.out_valid || {oif.out_last, oif.out_data} !== held)) stall_bad++;
      held_v = 1'b0;
      if (oif.out_valid) begin
        if (oif.out_ready) begin
          got_q.push_back(oif.out_data);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("word", oif.out_data, e);
            check("last_flag", OW'(oif.out_last), OW'(exp_q.size() == 0));
          end else begin
            check("extra_word", OW'(oif.out_valid), '0);
          end
          if (oif.out_last) begin
            n_last++;
            last_cyc = cyc;
          end
          if (abort_words > 0 && got_q.size() == abort_words) fin = 1'b1;
        end else begin
          held   = {oif.out_last, oif.out_data};
          held_v = 1'b1;
        end
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("finished_in_budget", OW'(fin), OW'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_drain"}, OW'(drain), '0);
    check({tag, "_busy"}, OW'(busy), '0);
    check({tag, "_done"}, OW'(done), '0);
    check({tag, "_valid"}, OW'(oif.out_valid), '0);
    check({tag, "_last"}, OW'(oif.out_last), '0);
    check({tag, "_data"}, oif.out_data, '0);
    check({tag, "_state"}, OW'(state_dbg), '0);
  endtask

  initial begin
    oif.out_ready = 1'b0;
    // Reset state
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Full 8x8 tile, ready held high
    run_tile(8, 8, 0, 0, 0);
    check("full_count", OW'(got_q.size()), OW'(32));
    check("full_word0", got_q[0], {32'd1, 32'd0});
    check("full_word31", got_q[31], {32'd119, 32'd118});
    check("full_last_cyc", OW'(last_cyc), OW'(48));
    check("full_done_cyc", OW'(done_cyc), OW'(49));
    check("full_drains", OW'(n_drain), OW'(8));
    check("full_busy_cycles", OW'(busy_cyc), OW'(49));
    check("full_n_last", OW'(n_last), OW'(1));
    check("full_exp_left", OW'(exp_q.size()), '0);
    #1;
    check("full_busy_after", OW'(busy), '0);
    check("full_done_after", OW'(done), '0);
    @(negedge clk);

    // Partial 3x5 tile, with an ignored start pulse while busy
    run_tile(3, 5, 0, 4, 0);
    check("part_count", OW'(got_q.size()), OW'(9));
    check("part_word2", got_q[2], 64'd4);
    check("part_word5", got_q[5], 64'd20);
    check("part_word8", got_q[8], 64'd36);
    check("part_last_cyc", OW'(last_cyc), OW'(15));
    check("part_done_cyc", OW'(done_cyc), OW'(16));
    check("part_drains", OW'(n_drain), OW'(3));
    check("part_n_last", OW'(n_last), OW'(1));

    // Backpressure with ready pattern 1,0,0,1
    run_tile(4, 6, 1, 0, 0);
    check("bp_count", OW'(got_q.size()), OW'(12));
    check("bp_exp_left", OW'(exp_q.size()), '0);
    check("bp_stall_stable", OW'(stall_bad), '0);
    check("bp_drain_in_send", OW'(drain_in_send), '0);
    check("bp_drains", OW'(n_drain), OW'(4));
    check("bp_n_last", OW'(n_last), OW'(1));

    // Empty tiles
    run_tile(0, 5, 0, 0, 0);
    check("rows0_done_cyc", OW'(done_cyc), OW'(1));
    check("rows0_drains", OW'(n_drain), '0);
    check("rows0_words", OW'(got_q.size()), '0);
    run_tile(3, 0, 0, 0, 0);
    check("cols0_done_cyc", OW'(done_cyc), OW'(1));
    check("cols0_drains", OW'(n_drain), '0);

    // Oversized request clamps to 8x8
    run_tile(15, 9, 0, 0, 0);
    check("clamp_count", OW'(got_q.size()), OW'(32));
    check("clamp_done_cyc", OW'(done_cyc), OW'(49));
    check("clamp_drains", OW'(n_drain), OW'(8));

    // Reset in the middle of row 4, then a fresh tile restarts at row 0
    run_tile(8, 8, 0, 0, 13);
    check("mid_valid_before", OW'(oif.out_valid), OW'(1));
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_tile(2, 8, 0, 0, 0);
    check("after_rst_word0", got_q[0], {32'd1, 32'd0});
    check("after_rst_count", OW'(got_q.size()), OW'(8));
    check("after_rst_done_cyc", OW'(done_cyc), OW'(13));

    // Negative and positive lanes through the optional clamp
    acc_mode = 1;
    run_tile(1, 2, 0, 0, 0);
    check("relu_lane0", OW'(got_q[0][31:0]), OW'(NEG_OUT));
    check("relu_lane1", OW'(got_q[0][63:32]), OW'(7));
    check("relu_done_cyc", OW'(done_cyc), OW'(4));
    acc_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
